arb_mux_n: RTL and testbench
============================

// Module: arb_mux_n
// PURPOSE
// N-input arbitrating multiplexer: parametrised successor to the fixed 8:1/16:4 priority-encode + mux
// blocks. Selects one of N valid/ready request channels (fixed-priority or round-robin), registers the
// winner's data and index into a single output stage, and holds it until the consumer accepts it.
// Sits between multiple producers and one shared datapath port (bus master select, shared ALU input).
// PARAMETERS
// N      8   number of request channels; N >= 2
// WIDTH  16  data width per channel
// MODE   1   0 = fixed priority (highest index wins), 1 = round-robin
// IDXW   $clog2(N)  derived localparam, width of winner index (not overridable)
// PORTS
// clk        in   1        single clock, rising edge
// rst_n      in   1        synchronous active-low reset
// req_valid  in   N        per-channel request valid
// req_data   in   N*WIDTH  channel i data at [i*WIDTH +: WIDTH]
// req_ready  out  N        per-channel accept; one-hot or zero
// out_valid  out  1        registered output holds a grant
// out_data   out  WIDTH    registered winner data
// out_idx    out  IDXW     registered winner channel index
// out_ready  in   1        consumer accepts out_* this cycle
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): out_valid=0, out_data=0, out_idx=0, last=0; req_ready forced 0
//   combinationally while rst_n=0. Reset mid-transfer discards the held grant; no channel is acked.
// - Load condition: load = !out_valid || out_ready. Arbitration only when load=1 and |req_valid.
// - req_ready[w]=1 combinationally for the winner w only when load=1; all others 0. Transfer on
//   channel i = req_valid[i] && req_ready[i]. req_ready never asserted for a non-valid channel.
// - On transfer: next edge out_valid=1, out_data=req_data[w], out_idx=w. Latency 1 cycle req->out.
// - If load=1 and no req_valid: out_valid<=0 (out_data/out_idx hold last values).
// - While out_valid=1 && out_ready=0: out_* stable, all req_ready=0 (stall; no overwrite).
// - Throughput: one transfer per cycle when out_ready held 1 (drain and refill same edge).
// - MODE=0: winner = highest set index of req_valid (matches existing priority encoders).
// - MODE=1: register last (IDXW) = index of last granted channel. Search order descending from
//   (last-1) mod N, wrapping through N-1 down to last; last itself lowest priority.
//   last updates to w only on a transfer. After reset last=0, so first search starts at N-1
//   (identical to MODE=0 for the first grant).
// - Request changes while stalled are not sampled; arbitration uses req_valid of the load cycle.
// - No state machine beyond out_valid (EMPTY/FULL) and last; both update only on clk edge.
// STRUCTURE
// - Package arb_pkg: localparams ARB_FIXED=0, ARB_RR=1; function rotate_right(vec,amt) for N-bit vec.
// - Sub-module priority_encode_n #(N): combinational highest-set-bit encoder, outputs idx (IDXW)
//   and valid; generalises the 8:3/16:4 encoders. RR mode feeds it req_valid rotated so that
//   channel (last-1) mod N lands at bit N-1, then un-rotates the index: w = (enc + last) mod N.
// - Data select: indexed part-select req_data[w*WIDTH +: WIDTH]; no N-way case statement.
// TESTING
// - Reset: hold rst_n=0 2 cycles with all req_valid=1 -> req_ready=0, out_valid=0, out_idx=0.
// - MODE=0, N=8: req_valid=8'b0010_0101, out_ready=1 -> grants 5 repeatedly; out_idx=5 each cycle.
// - MODE=1, N=8: req_valid=8'b1000_0011 held, out_ready=1 -> out_idx sequence 7,1,0,7,1,0.
// - Stall: grant ch3 data 16'hBEEF, out_ready=0 for 4 cycles with ch6 valid -> out_data=BEEF
//   stable, req_ready=0; out_ready=1 -> ch6 acked same cycle, out_idx=6 next cycle.
// - Idle drain: single transfer ch2, then req_valid=0, out_ready=1 -> out_valid falls 1 cycle after
//   acceptance; last stays 2 (next grant with all valid is ch1).
// - Reset mid-stall: out_valid=1 held, rst_n=0 one cycle -> out_valid=0, last=0, no req_ready seen.

Source files
------------

// File: rtl/arb_pkg.sv
// ============================================================================
// Module : arb_pkg
// Brief  : Shared constants, output-stage state type and rotate helper for
//          the N-input arbitrating multiplexer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package arb_pkg;

  localparam int ARB_FIXED  = 0;
  localparam int ARB_RR     = 1;

  // Upper bound on channel count supported by rotate_right (power of two).
  localparam int ARB_MAX_N  = 256;
  localparam int ARB_MAX_IW = 8;

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Rotate the low n bits of vec right by amt (amt < n); bits >= n read as 0.
  function automatic logic [ARB_MAX_N-1:0] rotate_right(
    input logic [ARB_MAX_N-1:0] vec,
    input int unsigned          amt,
    input int unsigned          n
  );
    logic [ARB_MAX_N-1:0] r;
    int unsigned          s;
    r = '0;
    for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
      if (i < n) begin
        s = i + amt;
        if (s >= n) s = s - n;
        r[ARB_MAX_IW'(i)] = vec[ARB_MAX_IW'(s)];
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/priority_encode_n.sv
// ============================================================================
// Module : priority_encode_n
// Brief  : Combinational highest-set-bit encoder, N inputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module priority_encode_n
  import arb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]         vec_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 valid_o
);

  localparam int IDXW = $clog2(N);

  // Ascending scan: the last set bit seen is the highest index.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) idx_o = IDXW'(i);
    end
  end

  assign valid_o = |vec_i;

endmodule

`default_nettype wire

// File: rtl/arb_mux_n.sv
// ============================================================================
// Module : arb_mux_n
// Brief  : N-channel valid/ready arbiter (fixed or round-robin) with a single
//          registered output stage holding the winner's data and index.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module arb_mux_n
  import arb_pkg::*;
#(
  parameter int N     = 8,
  parameter int WIDTH = 16,
  parameter int MODE  = ARB_RR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  input  logic [N*WIDTH-1:0]   req_data,
  output logic [N-1:0]         req_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [$clog2(N)-1:0] out_idx,
  input  logic                 out_ready
);

  localparam int IDXW = $clog2(N);

  out_state_e        state_q, state_d;
  logic [WIDTH-1:0]  data_q,  data_d;
  logic [IDXW-1:0]   idx_q,   idx_d;
  logic [IDXW-1:0]   last_q,  last_d;

  logic              w_load;
  logic [N-1:0]      w_enc_vec;
  logic [IDXW-1:0]   w_enc_idx;
  logic              w_enc_valid;
  logic [IDXW-1:0]   w_win;
  logic              w_grant;
  logic [WIDTH-1:0]  w_win_data;

  assign w_load = (state_q == OUT_EMPTY) || out_ready;

  generate
    if (MODE == ARB_RR) begin : g_rr
      localparam logic [IDXW:0] N_EXT = (IDXW+1)'(N);
      logic [IDXW:0] w_sum;

      // Rotating by last puts channel (last-1) mod N at bit N-1 of the encoder.
      assign w_enc_vec = N'(rotate_right(ARB_MAX_N'(req_valid), 32'(last_q), N));
      assign w_sum     = {1'b0, w_enc_idx} + {1'b0, last_q};
      assign w_win     = (w_sum >= N_EXT) ? IDXW'(w_sum - N_EXT) : w_sum[IDXW-1:0];
    end else begin : g_fixed
      assign w_enc_vec = req_valid;
      assign w_win     = w_enc_idx;
    end
  endgenerate

  priority_encode_n #(
    .N (N)
  ) u_enc (
    .vec_i   (w_enc_vec),
    .idx_o   (w_enc_idx),
    .valid_o (w_enc_valid)
  );

  assign w_grant    = rst_n && w_load && w_enc_valid;
  assign req_ready  = w_grant ? (N'(1) << w_win) : '0;
  assign w_win_data = req_data[32'(w_win) * WIDTH +: WIDTH];

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (w_load) begin
      if (w_enc_valid) begin
        state_d = OUT_FULL;
        data_d  = w_win_data;
        idx_d   = w_win;
        last_d  = w_win;
      end else begin
        state_d = OUT_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= OUT_EMPTY;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = (state_q == OUT_FULL);
  assign out_data  = data_q;
  assign out_idx   = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_arb_mux_n.sv
// ============================================================================
// Module : tb_arb_mux_n
// Brief  : Self-checking bench for arb_mux_n, fixed and round-robin instances.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_arb_mux_n;

  localparam int N  = 8;
  localparam int WD = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*WD-1:0] req_data;
  logic            out_ready;

  logic [N-1:0]    rdy_fx, rdy_rr;
  logic            ov_fx, ov_rr;
  logic [WD-1:0]   od_fx, od_rr;
  logic [2:0]      oi_fx, oi_rr;

  int total = 0;
  int bad   = 0;

  // Reference state per mode: [0] fixed priority, [1] round-robin.
  logic          m_v[2];
  logic [WD-1:0] m_d[2];
  int            m_i[2];
  int            m_last[2];

  always #5 clk = ~clk;

  arb_mux_n #(.N(N), .WIDTH(WD), .MODE(0)) dut_fx (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy_fx), .out_valid(ov_fx), .out_data(od_fx), .out_idx(oi_fx),
    .out_ready(out_ready)
  );

  arb_mux_n #(.N(N), .WIDTH(WD), .MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy_rr), .out_valid(ov_rr), .out_data(od_rr), .out_idx(oi_rr),
    .out_ready(out_ready)
  );

  function automatic int win_of(int mode, logic [N-1:0] v, int last);
    int ch;
    if (mode == 0) begin
      for (int k = N-1; k >= 0; k--) if (v[k]) return k;
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      ch = (last + N - k) % N;
      if (v[ch]) return ch;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    int           w;
    logic [N-1:0] e;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      e = '0;
      w = win_of(m, req_valid, m_last[m]);
      if (rst_n && (!m_v[m] || out_ready) && w >= 0) e[w] = 1'b1;
      chk(m == 0 ? "req_ready_fx" : "req_ready_rr", m == 0 ? rdy_fx : rdy_rr, e);
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      w = win_of(m, req_valid, m_last[m]);
      if (!rst_n) begin
        m_v[m] = 1'b0; m_d[m] = '0; m_i[m] = 0; m_last[m] = 0;
      end else if (!m_v[m] || out_ready) begin
        if (w >= 0) begin
          m_v[m] = 1'b1; m_d[m] = req_data[w*WD +: WD]; m_i[m] = w; m_last[m] = w;
        end else begin
          m_v[m] = 1'b0;
        end
      end
    end
    #1;
    chk("out_valid_fx", ov_fx, m_v[0]);
    chk("out_data_fx",  od_fx, m_d[0]);
    chk("out_idx_fx",   oi_fx, m_i[0]);
    chk("out_valid_rr", ov_rr, m_v[1]);
    chk("out_data_rr",  od_rr, m_d[1]);
    chk("out_idx_rr",   oi_rr, m_i[1]);
  endtask

  task automatic rand_data();
    for (int c = 0; c < N; c++) req_data[c*WD +: WD] = WD'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int rr_seq[6] = '{7, 1, 0, 7, 1, 0};
    for (int m = 0; m < 2; m++) begin
      m_v[m] = 1'b0; m_d[m] = '0; m_i[m] = 0; m_last[m] = 0;
    end
    rst_n = 1'b0; req_valid = '1; out_ready = 1'b1; rand_data();

    // Reset with every channel requesting.
    #1;
    chk("reset_ready_fx", rdy_fx, 0);
    chk("reset_ready_rr", rdy_rr, 0);
    cycle(); cycle();
    chk("reset_valid", ov_rr, 0);
    chk("reset_idx",   oi_rr, 0);

    // Fixed priority picks channel 5 every cycle.
    rst_n = 1'b1; req_valid = 8'b0010_0101;
    for (int k = 0; k < 3; k++) begin
      rand_data(); cycle();
      chk("fixed_idx5", oi_fx, 5);
    end

    // Round-robin rotation from a fresh reset.
    rst_n = 1'b0; cycle();
    rst_n = 1'b1; req_valid = 8'b1000_0011;
    for (int k = 0; k < 6; k++) begin
      rand_data(); cycle();
      chk("rr_sequence", oi_rr, rr_seq[k]);
    end

    // Stall: ch3 holds BEEF while ch6 waits.
    rst_n = 1'b0; cycle();
    rst_n = 1'b1; req_valid = 8'b0000_1000; req_data[3*WD +: WD] = 16'hBEEF;
    cycle();
    req_valid = 8'b0100_0000; out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rand_data(); cycle();
      chk("stall_data",  od_rr, 16'hBEEF);
      chk("stall_ready", rdy_rr, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_ready", rdy_rr, 8'b0100_0000);
    cycle();
    chk("stall_release_idx", oi_rr, 6);

    // Idle drain keeps last at 2.
    rst_n = 1'b0; cycle();
    rst_n = 1'b1; req_valid = 8'b0000_0100; rand_data(); cycle();
    req_valid = '0; cycle();
    chk("drain_valid", ov_rr, 0);
    req_valid = '1; cycle();
    chk("drain_next_rr", oi_rr, 1);
    chk("drain_next_fx", oi_fx, 7);

    // Reset while stalled.
    out_ready = 1'b0; cycle();
    rst_n = 1'b0;
    #1;
    chk("rst_stall_ready", rdy_rr, 0);
    cycle();
    chk("rst_stall_valid", ov_rr, 0);
    rst_n = 1'b1; out_ready = 1'b1; cycle();
    chk("rst_stall_regrant", oi_rr, 7);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      rst_n     = ($urandom_range(0, 39) != 0);
      req_valid = ($urandom_range(0, 1) != 0) ? N'($urandom) : N'($urandom & $urandom & $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
